// File: rtl/la_isoseq_pkg.sv
// Shared types and elaboration helpers for the la_isoseq isolation sequencer.
package la_isoseq_pkg;

   typedef enum logic [2:0] {
      ST_OFF    = 3'd0,
      ST_PWRUP  = 3'd1,
      ST_SETTLE = 3'd2,
      ST_ON     = 3'd3,
      ST_ISO    = 3'd4,
      ST_PWRDN  = 3'd5
   } state_t;

   // Counter must hold the largest terminal count without wrapping.
   function automatic int unsigned cnt_width(input int unsigned isodly,
                                             input int unsigned settle,
                                             input int unsigned timeout);
      int unsigned m;
      m = isodly;
      if (settle > m) m = settle;
      if (timeout > m) m = timeout;
      return (m < 1) ? 1 : $clog2(m + 1);
   endfunction

endpackage

// File: rtl/la_isoclamp.sv
// Per-bit isolation clamp: out = iso ? CLAMP : in.
module la_isoclamp #(
   parameter int unsigned    DW    = 8,
   parameter logic [DW-1:0]  CLAMP = '0,
   parameter                 PROP  = "DEFAULT"
) (
   input  logic          iso,
   input  logic [DW-1:0] in,
   output logic [DW-1:0] out
);

   if (PROP == "DEFAULT") begin : g_generic
      assign out = iso ? CLAMP : in;
   end else begin : g_tech
      // One mux per bit so a technology isolation cell can be swapped in here.
      for (genvar i = 0; i < int'(DW); i++) begin : g_bit
         assign out[i] = iso ? CLAMP[i] : in[i];
      end
   end

endmodule

// File: rtl/la_isoseq.sv
// Power-domain isolation sequencer: orders switch enable, ack, settle and iso release.
module la_isoseq
   import la_isoseq_pkg::*;
#(
   parameter int unsigned   DW      = 8,
   parameter logic [DW-1:0] CLAMP   = '0,
   parameter int unsigned   ISODLY  = 4,
   parameter int unsigned   SETTLE  = 8,
   parameter int unsigned   TIMEOUT = 256,
   parameter                PROP    = "DEFAULT"
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          pwr_req,
   input  logic          pwr_ack,
   output logic          pwr_en,
   input  logic [DW-1:0] in,
   output logic [DW-1:0] out,
   output logic          iso,
   output logic          ready,
   output logic          busy,
   output logic          err
);

   localparam int unsigned   CW         = cnt_width(ISODLY, SETTLE, TIMEOUT);
   localparam logic [CW-1:0] CNT_MAX    = '1;
   localparam logic [CW-1:0] ISO_LAST   = CW'(ISODLY - 1);
   localparam logic [CW-1:0] SET_LAST   = CW'(SETTLE - 1);
   localparam logic [CW-1:0] TMO_LAST   = CW'(TIMEOUT - 1);

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n, cnt_sat;
   logic          err_n;
   logic          pwr_en_n, iso_n, ready_n, busy_n;

   assign cnt_sat = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);

   // State, counter and registered control outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= ST_OFF;
         cnt    <= '0;
         err    <= 1'b0;
         pwr_en <= 1'b0;
         iso    <= 1'b1;
         ready  <= 1'b0;
         busy   <= 1'b0;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         err    <= err_n;
         pwr_en <= pwr_en_n;
         iso    <= iso_n;
         ready  <= ready_n;
         busy   <= busy_n;
      end
   end

   // Next state; every state change restarts the counter from zero.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      err_n   = err;
      case (state)
         ST_OFF: begin
            cnt_n = '0;
            if (pwr_req) begin
               state_n = ST_PWRUP;
               err_n   = 1'b0;
            end
         end
         ST_PWRUP: begin
            cnt_n = cnt_sat;
            if (!pwr_req) begin
               state_n = ST_PWRDN;
               cnt_n   = '0;
            end else if (pwr_ack) begin
               state_n = ST_SETTLE;
               cnt_n   = '0;
            end else if (cnt == TMO_LAST) begin
               state_n = ST_PWRDN;
               cnt_n   = '0;
               err_n   = 1'b1;
            end
         end
         ST_SETTLE: begin
            cnt_n = cnt_sat;
            if (!pwr_req) begin
               state_n = ST_PWRDN;
               cnt_n   = '0;
            end else if (!pwr_ack) begin
               state_n = ST_PWRDN;
               cnt_n   = '0;
               err_n   = 1'b1;
            end else if (cnt == SET_LAST) begin
               state_n = ST_ON;
               cnt_n   = '0;
            end
         end
         ST_ON: begin
            cnt_n = '0;
            if (!pwr_ack) err_n = 1'b1;
            if (!pwr_req || !pwr_ack) state_n = ST_ISO;
         end
         ST_ISO: begin
            cnt_n = cnt_sat;
            if (cnt == ISO_LAST) begin
               state_n = ST_PWRDN;
               cnt_n   = '0;
            end
         end
         ST_PWRDN: begin
            cnt_n = cnt_sat;
            if (!pwr_ack) begin
               state_n = ST_OFF;
               cnt_n   = '0;
            end else if (cnt == TMO_LAST) begin
               state_n = ST_OFF;
               cnt_n   = '0;
               err_n   = 1'b1;
            end
         end
         default: begin
            state_n = ST_OFF;
            cnt_n   = '0;
         end
      endcase
   end

   // Outputs decoded from the next state so they change on the transition edge.
   always_comb begin
      pwr_en_n = 1'b0;
      iso_n    = 1'b1;
      ready_n  = 1'b0;
      busy_n   = 1'b0;
      case (state_n)
         ST_PWRUP, ST_SETTLE, ST_ISO: begin
            pwr_en_n = 1'b1;
            busy_n   = 1'b1;
         end
         ST_ON: begin
            pwr_en_n = 1'b1;
            iso_n    = 1'b0;
            ready_n  = 1'b1;
         end
         ST_PWRDN: busy_n = 1'b1;
         default: ;
      endcase
   end

   la_isoclamp #(
      .DW    (DW),
      .CLAMP (CLAMP),
      .PROP  (PROP)
   ) u_clamp (
      .iso (iso),
      .in  (in),
      .out (out)
   );

endmodule

// File: tb/tb_la_isoseq.sv
// Directed bench for la_isoseq: power-up/down ordering, abort, timeout, brown-out.
module tb_la_isoseq;

   logic       clk = 1'b0;
   logic       reset;
   logic       pwr_req;
   logic       pwr_ack;
   logic       pwr_en;
   logic [7:0] in;
   logic [7:0] out;
   logic       iso;
   logic       ready;
   logic       busy;
   logic       err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   la_isoseq #(
      .DW      (8),
      .CLAMP   (8'hF0),
      .ISODLY  (4),
      .SETTLE  (8),
      .TIMEOUT (16),
      .PROP    ("DEFAULT")
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .pwr_req (pwr_req),
      .pwr_ack (pwr_ack),
      .pwr_en  (pwr_en),
      .in      (in),
      .out     (out),
      .iso     (iso),
      .ready   (ready),
      .busy    (busy),
      .err     (err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      reset   = 1'b1;
      pwr_req = 1'b1;
      pwr_ack = 1'b0;
      in      = 8'hA5;

      // Reset held with request high
      tick(3);
      check("rst_pwr_en", 32'(pwr_en), 32'd0);
      check("rst_iso",    32'(iso),    32'd1);
      check("rst_out",    32'(out),    32'hF0);
      check("rst_err",    32'(err),    32'd0);
      check("rst_busy",   32'(busy),   32'd0);
      check("rst_ready",  32'(ready),  32'd0);

      // Power-up: PWRUP four cycles without ack, then ack
      reset = 1'b0;
      tick(1);
      check("up_pwr_en", 32'(pwr_en), 32'd1);
      check("up_iso",    32'(iso),    32'd1);
      check("up_busy",   32'(busy),   32'd1);
      tick(4);
      pwr_ack = 1'b1;
      tick(1);
      check("settle0_iso", 32'(iso), 32'd1);
      tick(7);
      check("settle7_iso",  32'(iso),   32'd1);
      check("settle7_out",  32'(out),   32'hF0);
      tick(1);
      check("on_iso",   32'(iso),   32'd0);
      check("on_ready", 32'(ready), 32'd1);
      check("on_busy",  32'(busy),  32'd0);
      check("on_out",   32'(out),   32'hA5);
      in = 8'h3C;
      #1;
      check("on_out_pass", 32'(out), 32'h3C);

      // Power-down: iso on the request edge, pwr_en off ISODLY edges later
      pwr_req = 1'b0;
      tick(1);
      check("iso0_iso",    32'(iso),    32'd1);
      check("iso0_ready",  32'(ready),  32'd0);
      check("iso0_pwr_en", 32'(pwr_en), 32'd1);
      check("iso0_out",    32'(out),    32'hF0);
      pwr_req = 1'b1;
      tick(1);
      pwr_req = 1'b0;
      tick(1);
      tick(1);
      check("iso3_pwr_en", 32'(pwr_en), 32'd1);
      tick(1);
      check("pd_pwr_en", 32'(pwr_en), 32'd0);
      check("pd_busy",   32'(busy),   32'd1);
      tick(3);
      check("pd3_busy", 32'(busy), 32'd1);
      pwr_ack = 1'b0;
      tick(1);
      check("off_busy",   32'(busy),   32'd0);
      check("off_pwr_en", 32'(pwr_en), 32'd0);
      check("off_err",    32'(err),    32'd0);
      tick(1);
      check("off_stay_pwr_en", 32'(pwr_en), 32'd0);

      // Abort during SETTLE at count 3
      pwr_req = 1'b1;
      tick(1);
      pwr_ack = 1'b1;
      tick(1);
      tick(3);
      check("ab_iso", 32'(iso), 32'd1);
      pwr_req = 1'b0;
      tick(1);
      check("ab_pwr_en", 32'(pwr_en), 32'd0);
      check("ab_iso2",   32'(iso),    32'd1);
      check("ab_busy",   32'(busy),   32'd1);
      pwr_ack = 1'b0;
      tick(1);
      check("ab_off_busy", 32'(busy), 32'd0);
      check("ab_off_iso",  32'(iso),  32'd1);
      check("ab_off_err",  32'(err),  32'd0);

      // Ack timeout after 16 PWRUP cycles
      pwr_req = 1'b1;
      tick(1);
      tick(15);
      check("to15_pwr_en", 32'(pwr_en), 32'd1);
      check("to15_err",    32'(err),    32'd0);
      tick(1);
      check("to_err",    32'(err),    32'd1);
      check("to_pwr_en", 32'(pwr_en), 32'd0);
      pwr_req = 1'b0;
      tick(1);
      check("to_off_busy", 32'(busy), 32'd0);
      check("to_off_err",  32'(err),  32'd1);
      tick(1);
      check("to_off_err2", 32'(err), 32'd1);
      pwr_req = 1'b1;
      tick(1);
      check("to_clr_err",    32'(err),    32'd0);
      check("to_clr_pwr_en", 32'(pwr_en), 32'd1);

      // Brown-out while ON
      pwr_ack = 1'b1;
      tick(1);
      tick(8);
      check("bo_on_ready", 32'(ready), 32'd1);
      pwr_ack = 1'b0;
      tick(1);
      check("bo_err",    32'(err),    32'd1);
      check("bo_iso",    32'(iso),    32'd1);
      check("bo_ready",  32'(ready),  32'd0);
      check("bo_pwr_en", 32'(pwr_en), 32'd1);
      tick(3);
      check("bo_iso3_pwr_en", 32'(pwr_en), 32'd1);
      tick(1);
      check("bo_pd_pwr_en", 32'(pwr_en), 32'd0);
      tick(1);
      check("bo_off_busy", 32'(busy), 32'd0);
      check("bo_off_err",  32'(err),  32'd1);

      // Reset mid-sequence (request still high, so PWRUP is entered first)
      tick(1);
      check("mid_pwr_en", 32'(pwr_en), 32'd1);
      reset = 1'b1;
      tick(1);
      check("mid_rst_pwr_en", 32'(pwr_en), 32'd0);
      check("mid_rst_busy",   32'(busy),   32'd0);
      check("mid_rst_err",    32'(err),    32'd0);
      check("mid_rst_iso",    32'(iso),    32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
